// File: rtl/cpu_sequencer.sv
// Multicycle control sequencer. It owns the PC, fetches over a req/ack handshake, decodes the fixed
// instruction fields, applies the condition squash and steps LDR/STR through a data-memory handshake.
module cpu_sequencer #(
  parameter int          DATA_W  = 32,
  parameter int          PC_W    = 8,
  parameter int          CNT_W   = 16,
  parameter logic [3:0]  OP_LDR  = 4'hD,
  parameter logic [3:0]  OP_STR  = 4'hE,
  parameter logic [3:0]  OP_BR   = 4'hA,
  parameter logic [3:0]  OP_HALT = 4'hC,
  parameter logic [3:0]  OP_NOP  = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_req,
  input  logic              dmem_ack,
  input  logic              cond_met,
  output logic [3:0]        cond,
  output logic [3:0]        opcode,
  output logic              s,
  output logic [3:0]        dest,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic [4:0]        shamt,
  output logic [2:0]        shctl,
  output logic [15:0]       imm,
  output logic              reg_we,
  output logic              ldr_sel,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t              state_r;
  logic [DATA_W-1:0]   instr_r;
  logic                squash_r;
  logic [PC_W-1:0]     pc_r;
  logic [CNT_W-1:0]    retired_r;

  logic [31:0]         ins_s;
  logic [3:0]          op_raw_s;
  logic                is_ldr_s;
  logic                is_str_s;
  logic                is_br_s;
  logic                is_halt_s;
  logic                is_alu_s;
  logic                squash_now_s;
  logic [PC_W-1:0]     pc_inc_s;
  logic [CNT_W-1:0]    ret_inc_s;

  // Fields read as zero while fetching so the datapath never sees a stale instruction.
  assign ins_s        = (state_r == S_FETCH) ? 32'd0 : instr_r[31:0];
  assign op_raw_s     = ins_s[27:24];
  assign is_ldr_s     = (op_raw_s == OP_LDR);
  assign is_str_s     = (op_raw_s == OP_STR);
  assign is_br_s      = (op_raw_s == OP_BR);
  assign is_halt_s    = (op_raw_s == OP_HALT);
  assign is_alu_s     = !(is_ldr_s || is_str_s || is_br_s || is_halt_s);
  assign squash_now_s = (ins_s[31:28] != 4'd0) && !cond_met;
  assign pc_inc_s     = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
  assign ret_inc_s    = retired_r + {{(CNT_W-1){1'b0}}, 1'b1};

  // Sequencer state, PC, retired counter and latched instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_FETCH;
      instr_r   <= {DATA_W{1'b0}};
      squash_r  <= 1'b0;
      pc_r      <= {PC_W{1'b0}};
      retired_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        S_FETCH: begin
          if (imem_ack) begin
            instr_r  <= imem_rdata;
            squash_r <= 1'b0;
            state_r  <= S_DECODE;
          end
        end
        S_DECODE: begin
          squash_r <= squash_now_s;
          state_r  <= S_EXEC;
        end
        S_EXEC: begin
          if (squash_r) begin
            pc_r      <= pc_inc_s;
            retired_r <= ret_inc_s;
            state_r   <= S_FETCH;
          end else if (is_halt_s) begin
            retired_r <= ret_inc_s;
            state_r   <= S_HALT;
          end else if (is_br_s) begin
            pc_r      <= ins_s[PC_W+2:3];
            retired_r <= ret_inc_s;
            state_r   <= S_FETCH;
          end else if (is_ldr_s || is_str_s) begin
            state_r   <= S_MEM;
          end else begin
            pc_r      <= pc_inc_s;
            retired_r <= ret_inc_s;
            state_r   <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (is_str_s) begin
              pc_r      <= pc_inc_s;
              retired_r <= ret_inc_s;
              state_r   <= S_FETCH;
            end else begin
              state_r   <= S_WB;
            end
          end
        end
        S_WB: begin
          pc_r      <= pc_inc_s;
          retired_r <= ret_inc_s;
          state_r   <= S_FETCH;
        end
        S_HALT: state_r <= S_HALT;
        default: state_r <= S_FETCH;
      endcase
    end
  end

  // Handshake and strobes are pure decodes of the state register, so they drop the cycle after rst.
  assign imem_req  = (state_r == S_FETCH);
  assign imem_addr = pc_r;
  assign dmem_req  = (state_r == S_MEM);
  assign reg_we    = ((state_r == S_EXEC) && !squash_r && is_alu_s) || (state_r == S_WB);
  assign ldr_sel   = (state_r == S_WB);
  assign halted    = (state_r == S_HALT);
  assign pc        = pc_r;
  assign retired   = retired_r;

  assign cond   = ins_s[31:28];
  assign opcode = ((state_r == S_FETCH) || squash_r) ? OP_NOP : op_raw_s;
  assign s      = ins_s[23];
  assign dest   = is_ldr_s ? ins_s[18:15] : ins_s[22:19];
  assign src1   = ins_s[18:15];
  assign src2   = ins_s[14:11];
  assign shamt  = ins_s[10:6];
  assign shctl  = ins_s[2:0];
  assign imm    = ins_s[18:3];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-instruction expectations are queued when an instruction is
// issued and popped when the sequencer returns to fetch (or halts).
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_ack;
  logic        cond_met;
  logic [3:0]  cond, opcode, dest, src1, src2;
  logic        s;
  logic [4:0]  shamt;
  logic [2:0]  shctl;
  logic [15:0] imm;
  logic        reg_we, ldr_sel, halted;
  logic [7:0]  pc;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model_pc;
  logic [15:0] model_ret;
  logic [31:0] garbage;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] ret;
    int          we;
    logic        lsel;
    logic        halt;
    int          cyc;
    logic [3:0]  exop;
    logic [3:0]  dest;
  } exp_t;
  exp_t sb[$];

  cpu_sequencer dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .cond_met(cond_met),
    .cond(cond), .opcode(opcode), .s(s), .dest(dest), .src1(src1), .src2(src2),
    .shamt(shamt), .shctl(shctl), .imm(imm),
    .reg_we(reg_we), .ldr_sel(ldr_sel), .pc(pc), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] op,
                                     input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2);
    return {c, op, 1'b0, d, s1, s2, 11'h000};
  endfunction

  function automatic logic [31:0] mk_br(input logic [15:0] target);
    return {4'h0, 4'hA, 1'b0, 4'h0, target, 3'b000};
  endfunction

  // Issue one instruction: fetch after fd wait cycles, data ack after md wait cycles.
  task automatic do_instr(input string tag, input logic [31:0] instr, input int fd,
                          input logic cm, input int md);
    exp_t e;
    exp_t got;
    logic [3:0] op;
    logic sq;
    int cyc;
    int mem_wait;
    op       = instr[27:24];
    sq       = (instr[31:28] != 4'h0) && !cm;
    e.pc     = model_pc + 8'd1;
    e.ret    = model_ret + 16'd1;
    e.we     = 0;
    e.lsel   = 1'b0;
    e.halt   = 1'b0;
    e.cyc    = 3 + fd;
    e.exop   = sq ? 4'hF : op;
    e.dest   = (op == 4'hD) ? instr[18:15] : instr[22:19];
    if (!sq) begin
      if (op == 4'hC) begin
        e.pc = model_pc; e.halt = 1'b1;
      end else if (op == 4'hA) begin
        e.pc = instr[10:3];
      end else if (op == 4'hD) begin
        e.we = 1; e.lsel = 1'b1; e.cyc = 5 + fd + md;
      end else if (op == 4'hE) begin
        e.cyc = 4 + fd + md;
      end else begin
        e.we = 1;
      end
    end
    sb.push_back(e);

    chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    chk({tag, "_addr"}, {24'd0, imem_addr}, {24'd0, model_pc});
    imem_rdata = garbage;
    for (int i = 0; i < fd; i++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      chk({tag, "_req_held"}, {31'd0, imem_req}, 32'd1);
      chk({tag, "_addr_held"}, {24'd0, imem_addr}, {24'd0, model_pc});
    end
    imem_rdata = instr;
    imem_ack   = 1'b1;
    cond_met   = cm;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = garbage;
    chk({tag, "_dec_op"}, {28'd0, opcode}, {28'd0, op});
    chk({tag, "_dec_req"}, {31'd0, imem_req}, 32'd0);

    cyc = 0; mem_wait = 0;
    got.we = 0; got.lsel = 1'b0; got.dest = 4'h0; got.exop = 4'h0;
    while (!imem_req && !halted && cyc < 40) begin
      if (cyc == 1) got.exop = opcode;
      if (reg_we) begin
        got.we++; got.lsel = ldr_sel; got.dest = dest;
      end
      if (dmem_req) begin
        dmem_ack = (mem_wait == md);
        mem_wait++;
      end else begin
        dmem_ack = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    dmem_ack = 1'b0;
    chk({tag, "_timeout"}, {31'd0, (cyc >= 40)}, 32'd0);

    e = sb.pop_front();
    chk({tag, "_pc"}, {24'd0, pc}, {24'd0, e.pc});
    chk({tag, "_retired"}, {16'd0, retired}, {16'd0, e.ret});
    chk({tag, "_we_count"}, got.we, e.we);
    chk({tag, "_exec_op"}, {28'd0, got.exop}, {28'd0, e.exop});
    chk({tag, "_halted"}, {31'd0, halted}, {31'd0, e.halt});
    chk({tag, "_cycles"}, cyc + 1 + fd, e.cyc);
    if (e.we > 0) begin
      chk({tag, "_ldr_sel"}, {31'd0, got.lsel}, {31'd0, e.lsel});
      chk({tag, "_dest"}, {28'd0, got.dest}, {28'd0, e.dest});
    end
    model_pc  = e.pc;
    model_ret = e.ret;
  endtask

  initial begin
    garbage    = mk(4'h0, 4'hC, 4'h0, 4'h0, 4'h0);
    rst        = 1'b1;
    imem_rdata = 32'd0;
    imem_ack   = 1'b0;
    dmem_ack   = 1'b0;
    cond_met   = 1'b0;
    model_pc   = 8'd0;
    model_ret  = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_retired", {16'd0, retired}, 32'd0);
    chk("rst_reg_we", {31'd0, reg_we}, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_opcode", {28'd0, opcode}, 32'hF);
    chk("rst_imm", {16'd0, imm}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_instr("alu_fast",  mk(4'h0, 4'h1, 4'h2, 4'h3, 4'h4), 0, 1'b0, 0);
    do_instr("alu_wait3", mk(4'h0, 4'h2, 4'h5, 4'h6, 4'h7), 3, 1'b0, 0);
    do_instr("squash",    mk(4'h1, 4'h3, 4'h1, 4'h1, 4'h1), 0, 1'b0, 0);
    do_instr("cond_pass", mk(4'h1, 4'h4, 4'h9, 4'h1, 4'h1), 0, 1'b1, 0);
    do_instr("ldr",       mk(4'h0, 4'hD, 4'h3, 4'h7, 4'h0), 0, 1'b0, 2);
    do_instr("str",       mk(4'h0, 4'hE, 4'h3, 4'h7, 4'h0), 1, 1'b0, 1);
    do_instr("br_ff",     mk_br(16'h00FF), 0, 1'b0, 0);
    do_instr("pc_wrap",   mk(4'h0, 4'h5, 4'h2, 4'h2, 4'h2), 0, 1'b0, 0);
    do_instr("br_42",     mk_br(16'h0042), 2, 1'b0, 0);
    do_instr("alu_43",    mk(4'h0, 4'h6, 4'h8, 4'h1, 4'h2), 1, 1'b0, 0);

    // Reset while a data request is pending.
    imem_rdata = mk(4'h0, 4'hD, 4'h1, 4'h2, 4'h0);
    imem_ack   = 1'b1;
    @(negedge clk);
    imem_ack   = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_dmem_req", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("mid_rst_pc", {24'd0, pc}, 32'd0);
    chk("mid_rst_retired", {16'd0, retired}, 32'd0);
    chk("mid_rst_reg_we", {31'd0, reg_we}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_fetch", {31'd0, imem_req}, 32'd1);
    model_pc  = 8'd0;
    model_ret = 16'd0;

    do_instr("halt", mk(4'h0, 4'hC, 4'h0, 4'h0, 4'h0), 0, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = mk(4'h0, 4'h1, 4'h1, 4'h1, 4'h1);
      @(negedge clk);
      chk("halt_no_req", {31'd0, imem_req || dmem_req || reg_we}, 32'd0);
      chk("halt_stays", {31'd0, halted}, 32'd1);
    end
    imem_ack = 1'b0;
    chk("halt_pc", {24'd0, pc}, 32'd0);
    chk("halt_retired", {16'd0, retired}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
